seq_serializer: RTL and testbench

// - Parallel-to-serial front end for the serial sequence detector (pattern 1110010).
// - Accepts WIDTH-bit words over a valid/ready handshake.
// - Shifts each word out one bit per clock on sout, which drives the detector's serial input directly.
// - Back-to-back words stream with no gap bit, so patterns spanning word boundaries stay detectable.
// - Drives IDLE_BIT when no word is in flight.
//

---
 rtl/seq_serializer.sv | 94 +++++++++
 tb/tb_seq_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the 1110010 sequence detector.
// Words arrive on a valid/ready handshake and stream out one bit per clock, back-to-back with no gap.
//
// state    | meaning
// ST_IDLE  | no word in flight, sout = IDLE_BIT, ready for a word
// ST_SHIFT | shifting a word out, head of shift register on sout
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     clr,
  output logic                     sout,
  output logic                     sout_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_bit;
  logic             accept;

  assign last_bit  = (state_q == ST_SHIFT) && (idx_q == LAST_IDX);
  // Gated by rst_n so upstream sees "not ready" for the whole reset pulse.
  assign din_ready = rst_n & ((state_q == ST_IDLE) | last_bit);
  assign accept    = din_valid & din_ready & ~clr;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = ST_IDLE;
      shift_d = '0;
      idx_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_SHIFT;
        shift_d = din;
        idx_d   = '0;
      end
    end else if (!last_bit) begin
      if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], 1'b0};
      else           shift_d = {1'b0, shift_q[WIDTH-1:1]};
      idx_d = idx_q + 1'b1;
    end else if (accept) begin
      shift_d = din;
      idx_d   = '0;
    end else begin
      state_d = ST_IDLE;
      shift_d = '0;
      idx_d   = '0;
    end

    // sout is registered from next-state values so it never sees din/clr combinationally.
    sout_valid_d = (state_d == ST_SHIFT);
    sout_d       = IDLE_BIT;
    if (sout_valid_d) sout_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign bit_idx    = idx_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed word table, multi-cycle corner sequences, then
// random traffic against a bit-queue reference model. Two instances: MSB-first and LSB-first.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       clr = 1'b0;
  logic       rdy0, rdy1, sout0, sout1, sv0, sv1;
  logic [2:0] idx0, idx1;

  int tests = 0;
  int fails = 0;
  int det   = 0;
  logic [6:0] hist = '0;
  logic q0[$];
  logic q1[$];

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .clr(clr), .sout(sout0), .sout_valid(sv0), .bit_idx(idx0));

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .clr(clr), .sout(sout1), .sout_valid(sv1), .bit_idx(idx1));

  typedef struct {
    logic [7:0] word;
    logic [7:0] msb_stream;  // bits in send order, first bit at [7]
    logic [7:0] lsb_stream;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word accepted becomes 8 queued bits; the queue head is what sout shows.
  task automatic model_edge();
    bit ready;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      return;
    end
    ready = (q0.size() <= 1);
    if (clr) begin
      q0.delete(); q1.delete();
    end else begin
      if (q0.size() > 0) begin void'(q0.pop_front()); void'(q1.pop_front()); end
      if (din_valid && ready)
        for (int i = 0; i < 8; i++) begin
          q0.push_back(din[7-i]);
          q1.push_back(din[i]);
        end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    hist = {hist[5:0], sout0};
    if (hist == 7'b1110010) det++;
  endtask

  task automatic model_check();
    int n = q0.size();
    chk("mdl_valid", {31'b0, sv0}, {31'b0, n > 0});
    chk("mdl_sout", {31'b0, sout0}, {31'b0, (n > 0) ? q0[0] : 1'b0});
    chk("mdl_sout_lsb", {31'b0, sout1}, {31'b0, (n > 0) ? q1[0] : 1'b0});
    chk("mdl_idx", {29'b0, idx0}, (n > 0) ? 32'(8 - n) : 32'd0);
    chk("mdl_ready", {31'b0, rdy0}, {31'b0, n <= 1});
  endtask

  task automatic check_idle(input string name);
    chk({name, "_sout"}, {31'b0, sout0}, 32'd0);
    chk({name, "_valid"}, {31'b0, sv0}, 32'd0);
    chk({name, "_ready"}, {31'b0, rdy0}, 32'd1);
  endtask

  // Expects to be called at the negedge where bit 0 of the word is on sout.
  task automatic check_word(input string name, input logic [7:0] ms, input logic [7:0] ls, input bit chk_lsb);
    for (int i = 0; i < 8; i++) begin
      chk({name, "_sout"}, {31'b0, sout0}, {31'b0, ms[7-i]});
      if (chk_lsb) chk({name, "_sout_lsb"}, {31'b0, sout1}, {31'b0, ls[7-i]});
      chk({name, "_valid"}, {31'b0, sv0}, 32'd1);
      chk({name, "_idx"}, {29'b0, idx0}, 32'(i));
      step();
    end
  endtask

  task automatic send_pair(input string name, input logic [7:0] a, input logic [7:0] b);
    din = a; din_valid = 1'b1;
    step();
    din = b;
    for (int i = 0; i < 16; i++) begin
      chk({name, "_valid"}, {31'b0, sv0}, 32'd1);
      chk({name, "_sout"}, {31'b0, sout0}, {31'b0, (i < 8) ? a[7-i] : b[15-i]});
      chk({name, "_ready"}, {31'b0, rdy0}, {31'b0, (i % 8) == 7});
      if (i == 8) din_valid = 1'b0;
      step();
    end
    check_idle({name, "_end"});
  endtask

  initial begin
    int d0;
    vecs[0] = '{8'hE4, 8'b1110_0100, 8'b0010_0111};
    vecs[1] = '{8'h27, 8'b0010_0111, 8'b1110_0100};
    vecs[2] = '{8'h07, 8'b0000_0111, 8'b1110_0000};
    vecs[3] = '{8'hAA, 8'b1010_1010, 8'b0101_0101};
    vecs[4] = '{8'h81, 8'b1000_0001, 8'b1000_0001};
    vecs[5] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};

    #1;
    chk("rst_ready", {31'b0, rdy0}, 32'd0);
    chk("rst_valid", {31'b0, sv0}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("reset");
    chk("reset_idx", {29'b0, idx0}, 32'd0);

    // Single words from the table, both bit orders; E4 alone must fire the detector once.
    foreach (vecs[v]) begin
      d0 = det;
      din = vecs[v].word; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = ~vecs[v].word;
      check_word("tbl", vecs[v].msb_stream, vecs[v].lsb_stream, 1'b1);
      check_idle("tbl_end");
      chk("tbl_lsb_idle", {31'b0, sv1}, 32'd0);
      if (v == 0) chk("det_e4", 32'(det - d0), 32'd1);
      step();
    end

    send_pair("b2b", 8'hFF, 8'h00);
    step();
    d0 = det;
    send_pair("span", 8'h07, 8'h20);
    chk("det_span", 32'(det - d0), 32'd1);

    // clr at bit_idx 3 overrides a pending word, which is retried on the next edge.
    din = 8'hE4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (3) step();
    chk("clr_pre_idx", {29'b0, idx0}, 32'd3);
    din = 8'hAA; din_valid = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    check_idle("clr_abort");
    chk("clr_idx", {29'b0, idx0}, 32'd0);
    step();
    din_valid = 1'b0;
    check_word("clr_retry", 8'hAA, 8'h55, 1'b1);
    check_idle("clr_end");

    // Async reset mid-word at bit_idx 5.
    din = 8'hE4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (5) step();
    chk("rst5_pre_idx", {29'b0, idx0}, 32'd5);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("rst5_sout", {31'b0, sout0}, 32'd0);
    chk("rst5_valid", {31'b0, sv0}, 32'd0);
    chk("rst5_ready", {31'b0, rdy0}, 32'd0);
    chk("rst5_idx", {29'b0, idx0}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_idle("rst5_rel");
    din = 8'h3C; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check_word("rst5_next", 8'h3C, 8'h3C, 1'b1);

    // Random traffic against the queue model.
    q0.delete(); q1.delete();
    for (int c = 0; c < 800; c++) begin
      model_check();
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 29) == 0);
      step();
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
